// File: rtl/shop_v.sv
// shop_v: ASCII-driven login, user table and stock controller.
// One transaction per rising edge of i_rdy; o_a shows prompts and 1-clock status.
module shop_v #(
    parameter int I_A_NUM_ASCII_CHARS  = 7,
    parameter int O_A_NUM_ASCII_CHARS  = 9,
    parameter int I_U_NUM_BITS         = 4,
    parameter int MAX_USERS            = 5,
    parameter     ADMIN_USERNAME       = "Adm",
    parameter     ADMIN_PASSWORD       = "123",
    parameter     CMD_KEY__LOGOUT      = "Logout",
    parameter     CMD_KEY__LOGIN       = "Login",
    parameter     CMD_KEY__ADD_USER    = "AddUsr",
    parameter     CMD_KEY__DELETE_USER = "DelUsr",
    parameter     CMD_KEY__ADD_ITEM    = "AddItem",
    parameter     CMD_KEY__DELETE_ITEM = "DelItem",
    parameter     CMD_KEY__BUY         = "Buy",
    parameter     CMD_KEY__NONE        = "NONE"
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_rdy,
    input  logic [I_U_NUM_BITS-1:0]          i_u,
    input  logic [8*I_A_NUM_ASCII_CHARS-1:0] i_a,
    output logic [8*O_A_NUM_ASCII_CHARS-1:0] o_a
);
    localparam int I_A_NUM_BITS = 8 * I_A_NUM_ASCII_CHARS;
    localparam int O_A_NUM_BITS = 8 * O_A_NUM_ASCII_CHARS;
    localparam int SW = (MAX_USERS > 1) ? $clog2(MAX_USERS) : 1;
    localparam int CW = ((I_U_NUM_BITS > 8) ? I_U_NUM_BITS : 8) + 1;

    typedef logic [I_A_NUM_BITS-1:0] txt_t;
    typedef logic [O_A_NUM_BITS-1:0] msg_t;

    localparam txt_t ADM_NAME = txt_t'(ADMIN_USERNAME);
    localparam txt_t ADM_PASS = txt_t'(ADMIN_PASSWORD);
    localparam txt_t K_LOGOUT = txt_t'(CMD_KEY__LOGOUT);
    localparam txt_t K_LOGIN  = txt_t'(CMD_KEY__LOGIN);
    localparam txt_t K_ADDU   = txt_t'(CMD_KEY__ADD_USER);
    localparam txt_t K_DELU   = txt_t'(CMD_KEY__DELETE_USER);
    localparam txt_t K_ADDI   = txt_t'(CMD_KEY__ADD_ITEM);
    localparam txt_t K_DELI   = txt_t'(CMD_KEY__DELETE_ITEM);
    localparam txt_t K_BUY    = txt_t'(CMD_KEY__BUY);
    localparam txt_t K_NONE   = txt_t'(CMD_KEY__NONE);

    localparam msg_t M_CMD    = msg_t'("Cmd?");
    localparam msg_t M_UQ     = msg_t'("Username?");
    localparam msg_t M_PQ     = msg_t'("Password?");
    localparam msg_t M_ICMD   = msg_t'("InvalCmd");
    localparam msg_t M_IPERM  = msg_t'("InvalPerm");
    localparam msg_t M_IUSER  = msg_t'("InvalUser");
    localparam msg_t M_IPASS  = msg_t'("InvalPass");
    localparam msg_t M_LIN    = msg_t'("LoggedIn");
    localparam msg_t M_LOUT   = msg_t'("LoggedOut");
    localparam msg_t M_FULL   = msg_t'("DbFull");
    localparam msg_t M_UADD   = msg_t'("UserAdded");
    localparam msg_t M_UDEL   = msg_t'("UserDel");
    localparam msg_t M_IADD   = msg_t'("ItemAdded");
    localparam msg_t M_IDEL   = msg_t'("ItemDel");
    localparam msg_t M_BOUGHT = msg_t'("Bought");
    localparam msg_t M_NOSTK  = msg_t'("NoStock");

    typedef enum logic [2:0] {
        S_CMD, S_USERNAME, S_PASSWORD, S_NEW_NAME,
        S_NEW_PASS, S_DEL_NAME, S_MSG
    } state_t;

    state_t               state, state_d;
    msg_t                 o_a_d;
    logic                 rdy_q;
    logic [MAX_USERS-1:0] used;
    txt_t                 names [MAX_USERS];
    txt_t                 pwds  [MAX_USERS];
    logic                 cur_v, cur_v_d;
    logic [SW-1:0]        cur, cur_d;
    logic [SW-1:0]        pend, pend_d;
    txt_t                 pend_name, pend_name_d;
    logic [7:0]           stock, stock_d;

    logic                 txn, hit, free, is_admin, enough;
    logic [SW-1:0]        hit_idx, free_idx;
    logic [CW-1:0]        qty, sum;
    logic                 add_en, del_en;

    always_comb begin
        txn      = i_rdy & ~rdy_q;
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < MAX_USERS; i++) begin
            if (!hit && used[i] && names[i] == i_a) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
            if (!free && !used[i]) begin
                free     = 1'b1;
                free_idx = SW'(i);
            end
        end
        qty      = CW'(i_u);
        sum      = CW'(stock) + qty;
        enough   = qty <= CW'(stock);
        is_admin = cur_v && (cur == '0);

        state_d     = state;
        o_a_d       = o_a;
        cur_v_d     = cur_v;
        cur_d       = cur;
        pend_d      = pend;
        pend_name_d = pend_name;
        stock_d     = stock;
        add_en      = 1'b0;
        del_en      = 1'b0;

        unique case (state)
            S_MSG: begin
                state_d = S_CMD;
                o_a_d   = M_CMD;
            end
            S_CMD: if (txn) begin
                state_d = S_MSG;
                unique case (1'b1)
                    i_a == K_NONE: state_d = S_CMD;
                    i_a == K_LOGIN:
                        if (!cur_v) begin
                            state_d = S_USERNAME;
                            o_a_d   = M_UQ;
                        end else o_a_d = M_IPERM;
                    i_a == K_LOGOUT:
                        if (cur_v) begin
                            cur_v_d = 1'b0;
                            o_a_d   = M_LOUT;
                        end else o_a_d = M_IPERM;
                    i_a == K_ADDU:
                        if (is_admin) begin
                            state_d = S_NEW_NAME;
                            o_a_d   = M_UQ;
                        end else o_a_d = M_IPERM;
                    i_a == K_DELU:
                        if (is_admin) begin
                            state_d = S_DEL_NAME;
                            o_a_d   = M_UQ;
                        end else o_a_d = M_IPERM;
                    i_a == K_ADDI:
                        if (is_admin) begin
                            stock_d = (sum > CW'(255)) ? 8'hFF : sum[7:0];
                            o_a_d   = M_IADD;
                        end else o_a_d = M_IPERM;
                    i_a == K_DELI, i_a == K_BUY:
                        if (is_admin || (cur_v && i_a == K_BUY)) begin
                            if (enough) begin
                                stock_d = stock - qty[7:0];
                                o_a_d   = (i_a == K_BUY) ? M_BOUGHT : M_IDEL;
                            end else o_a_d = M_NOSTK;
                        end else o_a_d = M_IPERM;
                    default: o_a_d = M_ICMD;
                endcase
            end
            S_USERNAME: if (txn) begin
                if (hit) begin
                    pend_d  = hit_idx;
                    state_d = S_PASSWORD;
                    o_a_d   = M_PQ;
                end else begin
                    state_d = S_MSG;
                    o_a_d   = M_IUSER;
                end
            end
            S_PASSWORD: if (txn) begin
                state_d = S_MSG;
                if (used[pend] && pwds[pend] == i_a) begin
                    cur_v_d = 1'b1;
                    cur_d   = pend;
                    o_a_d   = M_LIN;
                end else o_a_d = M_IPASS;
            end
            S_NEW_NAME: if (txn) begin
                state_d = S_MSG;
                if (hit) o_a_d = M_IUSER;
                else if (!free) o_a_d = M_FULL;
                else begin
                    pend_name_d = i_a;
                    state_d     = S_NEW_PASS;
                    o_a_d       = M_PQ;
                end
            end
            S_NEW_PASS: if (txn) begin
                add_en  = 1'b1;
                state_d = S_MSG;
                o_a_d   = M_UADD;
            end
            S_DEL_NAME: if (txn) begin
                state_d = S_MSG;
                // the admin slot is permanent
                if (!hit || hit_idx == '0) o_a_d = M_IUSER;
                else begin
                    del_en = 1'b1;
                    o_a_d  = M_UDEL;
                end
            end
            default: begin
                state_d = S_CMD;
                o_a_d   = M_CMD;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_CMD;
            o_a       <= M_CMD;
            rdy_q     <= 1'b0;
            cur_v     <= 1'b0;
            cur       <= '0;
            pend      <= '0;
            pend_name <= '0;
            stock     <= '0;
            for (int i = 0; i < MAX_USERS; i++) begin
                used[i]  <= (i == 0);
                names[i] <= (i == 0) ? ADM_NAME : '0;
                pwds[i]  <= (i == 0) ? ADM_PASS : '0;
            end
        end else begin
            state     <= state_d;
            o_a       <= o_a_d;
            rdy_q     <= i_rdy;
            cur_v     <= cur_v_d;
            cur       <= cur_d;
            pend      <= pend_d;
            pend_name <= pend_name_d;
            stock     <= stock_d;
            if (add_en) begin
                used[free_idx]  <= 1'b1;
                names[free_idx] <= pend_name;
                pwds[free_idx]  <= i_a;
            end
            if (del_en) used[hit_idx] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shop_v.sv
// tb_shop_v: directed and random transactions against a behavioural shop model.
// The model predicts o_a every cycle; directed steps also pin literal responses.
module tb_shop_v;
    typedef logic [55:0] txt_t;
    typedef logic [71:0] msg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_rdy = 1'b0;
    logic [3:0] i_u = '0;
    txt_t i_a = '0;
    msg_t o_a;

    shop_v dut (
        .i_clk(clk), .i_reset(rst), .i_rdy(i_rdy),
        .i_u(i_u), .i_a(i_a), .o_a(o_a)
    );

    always #5 clk = ~clk;

    localparam txt_t K_LOGIN  = 56'("Login");
    localparam txt_t K_LOGOUT = 56'("Logout");
    localparam txt_t K_ADDU   = 56'("AddUsr");
    localparam txt_t K_DELU   = 56'("DelUsr");
    localparam txt_t K_ADDI   = 56'("AddItem");
    localparam txt_t K_DELI   = 56'("DelItem");
    localparam txt_t K_BUY    = 56'("Buy");
    localparam txt_t K_NONE   = 56'("NONE");
    localparam msg_t CMDQ     = msg_t'("Cmd?");
    localparam msg_t UQ       = msg_t'("Username?");
    localparam msg_t PQ       = msg_t'("Password?");

    int checks = 0;
    int errors = 0;

    // behavioural model state
    typedef enum {M_CMD, M_LNAME, M_LPASS, M_ANAME, M_APASS, M_DNAME} mode_e;
    mode_e m_mode;
    bit    m_in_msg, m_prev;
    int    m_who, m_pend, m_stock;
    bit    m_used [5];
    txt_t  m_name [5];
    txt_t  m_pass [5];
    txt_t  m_pname;
    msg_t  exp_oa;

    task automatic check(input string nm, input msg_t got, input msg_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got \"%s\" (%h) want \"%s\" (%h) at %0t",
                     nm, got, got, want, want, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic m_reset();
        m_mode = M_CMD; m_in_msg = 0; m_prev = 0;
        m_who = -1; m_pend = 0; m_stock = 0; m_pname = '0;
        for (int i = 0; i < 5; i++) begin
            m_used[i] = (i == 0);
            m_name[i] = (i == 0) ? 56'("Adm") : '0;
            m_pass[i] = (i == 0) ? 56'("123") : '0;
        end
        exp_oa = CMDQ;
    endtask

    function automatic int m_find(input txt_t n);
        for (int i = 0; i < 5; i++)
            if (m_used[i] && m_name[i] == n) return i;
        return -1;
    endfunction

    function automatic bit m_allowed(input txt_t a);
        if (m_who < 0) return a == K_LOGIN;
        if (a == K_LOGOUT || a == K_BUY) return 1;
        return m_who == 0 && (a inside {K_ADDU, K_DELU, K_ADDI, K_DELI});
    endfunction

    task automatic say(input msg_t m);
        exp_oa = m; m_in_msg = 1; m_mode = M_CMD;
    endtask

    task automatic ask(input mode_e md, input msg_t m);
        exp_oa = m; m_mode = md;
    endtask

    task automatic m_step(input txt_t a, input int u);
        int idx, n;
        case (m_mode)
            M_CMD: begin
                if (a == K_NONE) begin end
                else if (!(a inside {K_LOGIN, K_LOGOUT, K_ADDU, K_DELU,
                                     K_ADDI, K_DELI, K_BUY}))
                    say(msg_t'("InvalCmd"));
                else if (!m_allowed(a)) say(msg_t'("InvalPerm"));
                else if (a == K_LOGIN) ask(M_LNAME, UQ);
                else if (a == K_LOGOUT) begin m_who = -1; say(msg_t'("LoggedOut")); end
                else if (a == K_ADDU) ask(M_ANAME, UQ);
                else if (a == K_DELU) ask(M_DNAME, UQ);
                else if (a == K_ADDI) begin
                    m_stock = (m_stock + u > 255) ? 255 : m_stock + u;
                    say(msg_t'("ItemAdded"));
                end else if (u <= m_stock) begin
                    m_stock -= u;
                    say(a == K_BUY ? msg_t'("Bought") : msg_t'("ItemDel"));
                end else say(msg_t'("NoStock"));
            end
            M_LNAME: begin
                idx = m_find(a);
                if (idx < 0) say(msg_t'("InvalUser"));
                else begin m_pend = idx; ask(M_LPASS, PQ); end
            end
            M_LPASS:
                if (m_pass[m_pend] == a) begin m_who = m_pend; say(msg_t'("LoggedIn")); end
                else say(msg_t'("InvalPass"));
            M_ANAME: begin
                n = 0;
                foreach (m_used[i]) n += m_used[i];
                if (m_find(a) >= 0) say(msg_t'("InvalUser"));
                else if (n == 5) say(msg_t'("DbFull"));
                else begin m_pname = a; ask(M_APASS, PQ); end
            end
            M_APASS: begin
                idx = 0;
                while (m_used[idx]) idx++;
                m_used[idx] = 1; m_name[idx] = m_pname; m_pass[idx] = a;
                say(msg_t'("UserAdded"));
            end
            M_DNAME: begin
                idx = m_find(a);
                if (idx <= 0) say(msg_t'("InvalUser"));
                else begin m_used[idx] = 0; say(msg_t'("UserDel")); end
            end
            default: m_mode = M_CMD;
        endcase
    endtask

    initial begin
        bit fire;
        m_reset();
        forever begin
            @(posedge clk);
            if (rst) m_reset();
            else begin
                fire = i_rdy && !m_prev;
                m_prev = i_rdy;
                if (m_in_msg) begin m_in_msg = 0; exp_oa = CMDQ; end
                else if (fire) m_step(i_a, int'(i_u));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) check("model_oa", o_a, exp_oa);
        end
    end

    function automatic bit is_msg(input msg_t m);
        return !(m inside {CMDQ, UQ, PQ});
    endfunction

    task automatic send(input txt_t a, input int u, input msg_t want, input bit lit);
        @(negedge clk);
        i_a = a; i_u = 4'(u); i_rdy = 1'b1;
        @(posedge clk); #1;
        if (lit) check("resp", o_a, want);
        @(negedge clk);
        i_a = 56'({$urandom(), $urandom()}); i_u = 4'($urandom());
        @(posedge clk); #1;
        if (lit && is_msg(want)) check("cmd_after_msg", o_a, CMDQ);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        i_rdy = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    txt_t pool [$];

    initial begin
        do_reset();
        @(posedge clk); #1;
        check("reset_oa", o_a, CMDQ);

        send(56'("sdfsdf"), 0, msg_t'("InvalCmd"), 1);
        send(K_ADDI, 3, msg_t'("InvalPerm"), 1);
        check_int("stock_after_perm", m_stock, 0);
        send(K_LOGIN, 0, UQ, 1);
        send(56'("Uun"), 0, msg_t'("InvalUser"), 1);
        send(K_NONE, 0, CMDQ, 1);

        send(K_LOGIN, 0, UQ, 1);
        send(56'("Adm"), 0, PQ, 1);
        send(56'("123"), 0, msg_t'("LoggedIn"), 1);
        send(K_ADDI, 5, msg_t'("ItemAdded"), 1);
        send(K_BUY, 7, msg_t'("NoStock"), 1);
        send(K_BUY, 5, msg_t'("Bought"), 1);
        check_int("stock_after_buy", m_stock, 0);
        send(K_BUY, 1, msg_t'("NoStock"), 1);

        send(K_ADDU, 0, UQ, 1);
        send(56'("Bob"), 0, PQ, 1);
        send(56'("pw"), 0, msg_t'("UserAdded"), 1);
        send(K_ADDU, 0, UQ, 1); send(56'("Amy"), 0, PQ, 1);
        send(56'("a1"), 0, msg_t'("UserAdded"), 1);
        send(K_ADDU, 0, UQ, 1); send(56'("Cy"), 0, PQ, 1);
        send(56'("c1"), 0, msg_t'("UserAdded"), 1);
        send(K_ADDU, 0, UQ, 1); send(56'("Dee"), 0, PQ, 1);
        send(56'("d1"), 0, msg_t'("UserAdded"), 1);
        send(K_ADDU, 0, UQ, 1);
        send(56'("Eve"), 0, msg_t'("DbFull"), 1);
        send(K_ADDU, 0, UQ, 1);
        send(56'("Bob"), 0, msg_t'("InvalUser"), 1);
        send(K_DELU, 0, UQ, 1);
        send(56'("Adm"), 0, msg_t'("InvalUser"), 1);
        send(K_DELU, 0, UQ, 1);
        send(56'("Cy"), 0, msg_t'("UserDel"), 1);
        send(K_ADDU, 0, UQ, 1); send(56'("Eve"), 0, PQ, 1);
        send(56'("e1"), 0, msg_t'("UserAdded"), 1);
        check_int("eve_slot", m_find(56'("Eve")), 3);

        for (int i = 0; i < 18; i++) send(K_ADDI, 15, msg_t'("ItemAdded"), 1);
        check_int("stock_sat", m_stock, 255);
        send(K_DELI, 0, msg_t'("ItemDel"), 1);
        send(K_DELI, 15, msg_t'("ItemDel"), 1);
        check_int("stock_del", m_stock, 240);
        send(K_LOGOUT, 0, msg_t'("LoggedOut"), 1);

        send(K_LOGIN, 0, UQ, 1); send(56'("Bob"), 0, PQ, 1);
        send(56'("xx"), 0, msg_t'("InvalPass"), 1);
        send(K_LOGIN, 0, UQ, 1); send(56'("Bob"), 0, PQ, 1);
        send(56'("pw"), 0, msg_t'("LoggedIn"), 1);
        send(K_ADDU, 0, msg_t'("InvalPerm"), 1);
        send(K_LOGIN, 0, msg_t'("InvalPerm"), 1);
        send(K_BUY, 0, msg_t'("Bought"), 1);
        send(K_BUY, 10, msg_t'("Bought"), 1);
        check_int("stock_user_buy", m_stock, 230);

        send(K_LOGOUT, 0, msg_t'("LoggedOut"), 1);
        send(K_LOGIN, 0, UQ, 1);
        do_reset();
        @(posedge clk); #1;
        check("reset_mid_txn", o_a, CMDQ);
        send(56'("Adm"), 0, msg_t'("InvalCmd"), 1);
        send(K_LOGIN, 0, UQ, 1);
        send(56'("Bob"), 0, msg_t'("InvalUser"), 1);
        send(K_BUY, 0, msg_t'("InvalPerm"), 1);

        pool = '{K_LOGIN, K_LOGOUT, K_ADDU, K_DELU, K_ADDI, K_DELI, K_BUY,
                 K_NONE, 56'("sdfsdf"), 56'("Adm"), 56'("123"), 56'("Bob"),
                 56'("pw"), 56'("Amy"), 56'("a1"), 56'("Cy"), 56'("Dee"),
                 56'("Eve"), 56'("xx")};
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                send(K_LOGOUT, 0, CMDQ, 0);
                send(K_LOGIN, 0, CMDQ, 0);
                send(56'("Adm"), 0, CMDQ, 0);
                send(56'("123"), 0, CMDQ, 0);
            end
            send(pool[$urandom_range(0, pool.size() - 1)],
                 int'($urandom_range(0, 15)), CMDQ, 0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shop_v.md
SHOP_V -- requirements
Module: shop_v

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- I_A_NUM_ASCII_CHARS, 7, input text width in chars; I_A_NUM_BITS = 8*this.
- O_A_NUM_ASCII_CHARS, 9, output text width in chars; O_A_NUM_BITS = 8*this.
- I_U_NUM_BITS, 4, quantity input width.
- MAX_USERS, 5, user-table slots, admin included.
- ADMIN_USERNAME, "Adm", admin name; ADMIN_PASSWORD, "123", admin password.
- CMD_KEY__LOGOUT "Logout", CMD_KEY__LOGIN "Login", CMD_KEY__ADD_USER "AddUsr", CMD_KEY__DELETE_USER "DelUsr", CMD_KEY__ADD_ITEM "AddItem", CMD_KEY__DELETE_ITEM "DelItem", CMD_KEY__BUY "Buy", CMD_KEY__NONE "NONE": command keywords.
REQ-002 Ports (name, direction, width, meaning):
- i_clk, in, 1, single clock, rising edge.
- i_reset, in, 1, reset, asynchronous, active-high.
- i_rdy, in, 1, input-valid strobe.
- i_u, in, I_U_NUM_BITS, unsigned quantity (item commands only).
- i_a, in, I_A_NUM_BITS, ASCII command/name/password.
- o_a, out, O_A_NUM_BITS, ASCII prompt/status, registered.
REQ-003 All text is right-justified ASCII, upper bytes zero-padded, last char in bits [7:0]; comparisons are exact full-width equality.

Function
REQ-004 A transaction is a rising edge of i_rdy (registered; low on prior clock, high on current); each rdy pulse is exactly one transaction however long held; i_a/i_u sampled that cycle, ignored otherwise (X allowed).
REQ-005 o_a updates on the clock after the sampled edge (1-cycle latency).
REQ-006 Error/status messages hold exactly 1 clock, then o_a returns to "Cmd?" with state CMD; prompts hold until next transaction.
REQ-007 States: CMD, USERNAME, PASSWORD, NEW_NAME, NEW_PASS, DEL_NAME, MSG.
REQ-008 CMD, unknown keyword -> "InvalCmd"; "NONE" -> no message, stays "Cmd?".
REQ-009 Permissions: logged out: Login only; user: Logout, Buy; admin: Logout, Buy, AddUsr, DelUsr, AddItem, DelItem; any other known keyword -> "InvalPerm".
REQ-010 Login -> USERNAME, "Username?"; name in occupied slot -> PASSWORD, "Password?", else "InvalUser"; password matching that slot -> current user = slot, "LoggedIn", else "InvalPass".
REQ-011 Logout -> current user cleared, "LoggedOut".
REQ-012 AddUsr -> NEW_NAME "Username?"; existing name -> "InvalUser"; table full -> "DbFull"; else NEW_PASS "Password?", stored in lowest free slot -> "UserAdded".
REQ-013 DelUsr -> DEL_NAME "Username?"; name absent or admin -> "InvalUser"; else slot freed -> "UserDel".
REQ-014 Stock: 8-bit unsigned count. AddItem: stock += i_u, saturating at 255 -> "ItemAdded". DelItem/Buy: i_u <= stock -> stock -= i_u, "ItemDel"/"Bought"; else unchanged, "NoStock"; i_u=0 succeeds, no change.
REQ-015 Slot 0 is admin, never freed; names/passwords stored at I_A_NUM_BITS.

Reset
REQ-016 i_reset high, asynchronous: state CMD, o_a "Cmd?", nobody logged in, slot 0 = ADMIN_USERNAME/ADMIN_PASSWORD, slots 1..4 empty, stock 0, rdy edge register 0.
REQ-017 Reset mid-transaction aborts it, no table/stock change; first i_rdy high after reset counts as an edge only if sampled low earlier.

Verification
REQ-018 Reset, logged out, "sdfsdf" -> "InvalCmd" 1 clock, then "Cmd?".
REQ-019 Logged out, "AddItem" -> "InvalPerm", then "Cmd?"; stock stays 0.
REQ-020 Logged out, "Login" -> "Username?"; "Uun" -> "InvalUser", then "Cmd?".
REQ-021 Login, "Adm", "123" -> "Password?", "LoggedIn"; AddItem i_u=5 -> stock 5; Buy i_u=7 -> "NoStock"; Buy i_u=5 -> "Bought", stock 0.
REQ-022 Admin: AddUsr "Bob"/"pw" -> "UserAdded"; 3 more adds -> "UserAdded" x3; 5th -> "DbFull"; DelUsr "Adm" -> "InvalUser"; Logout -> "LoggedOut".
REQ-023 Login "Bob" wrong password "xx" -> "InvalPass"; correct -> "LoggedIn"; "AddUsr" -> "InvalPerm".
